// File: rtl/err_watchdog_pkg.sv
// Shared state and error-code encodings for the err_watchdog block.
package err_watchdog_pkg;

  localparam int unsigned ERR_CODE_W = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef enum logic [ERR_CODE_W-1:0] {
    EC_NONE      = 2'd0,
    EC_TIMEOUT   = 2'd1,
    EC_SRC       = 2'd2,
    EC_POST_HALT = 2'd3
  } err_code_e;

endpackage

// File: rtl/err_watchdog_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module err_watchdog_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/err_watchdog.sv
// Heartbeat watchdog and sticky fault capture; drives a registered err toward the clock/reset generator.
module err_watchdog
  import err_watchdog_pkg::*;
#(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned WDW     = 16,
  parameter int unsigned CYW     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  heartbeat,
  input  logic                  halt,
  input  logic [NSRC-1:0]       src_err,
  output logic                  err,
  output logic [ERR_CODE_W-1:0] err_code,
  output logic [NSRC-1:0]       err_src,
  output logic                  done,
  output logic [CYW-1:0]        cycles
);

  if ((64'd1 << WDW) <= 64'(TIMEOUT)) begin : g_bad_wdw
    $error("err_watchdog: WDW too narrow for TIMEOUT");
  end

  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e         state;
  err_code_e      code_q;
  logic [WDW-1:0] wd_cnt;

  assign err_code = code_q;

  // Priority within RUN: source error, halt, heartbeat, timeout, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      wd_cnt  <= '0;
      err     <= 1'b0;
      code_q  <= EC_NONE;
      err_src <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (src_err != '0) begin
            state   <= ST_FAULT;
            err     <= 1'b1;
            code_q  <= EC_SRC;
            err_src <= src_err;
          end else if (halt) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (heartbeat) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            state   <= ST_FAULT;
            err     <= 1'b1;
            code_q  <= EC_TIMEOUT;
            err_src <= '0;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        ST_DONE: begin
          if (src_err != '0) begin
            state   <= ST_FAULT;
            err     <= 1'b1;
            code_q  <= EC_POST_HALT;
            err_src <= src_err;
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  // Counts the edge that leaves RUN too, since state is still RUN when it is sampled.
  err_watchdog_sat_counter #(
    .W(CYW)
  ) u_cycles (
    .clk(clk),
    .clr(rst),
    .en (state == ST_RUN),
    .q  (cycles)
  );

endmodule

// File: tb/tb_err_watchdog.sv
// Scenario bench for err_watchdog: expected output snapshots are queued with stimulus and checked after each edge.
module tb_err_watchdog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        heartbeat = 1'b0;
  logic        halt = 1'b0;
  logic [3:0]  src_err = 4'h0;

  logic        err;
  logic [1:0]  err_code;
  logic [3:0]  err_src;
  logic        done;
  logic [31:0] cycles;

  logic        s_err;
  logic [1:0]  s_err_code;
  logic [3:0]  s_err_src;
  logic        s_done;
  logic [7:0]  s_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_q[$];
  logic [39:0] obs;
  logic [39:0] e;

  assign obs = {err, err_code, err_src, done, cycles};

  always #5 clk = ~clk;

  err_watchdog #(.NSRC(4), .TIMEOUT(16), .WDW(16), .CYW(32)) dut (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .halt(halt), .src_err(src_err),
    .err(err), .err_code(err_code), .err_src(err_src), .done(done), .cycles(cycles)
  );

  err_watchdog #(.NSRC(4), .TIMEOUT(16), .WDW(16), .CYW(8)) dut_sat (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .halt(halt), .src_err(src_err),
    .err(s_err), .err_code(s_err_code), .err_src(s_err_src), .done(s_done), .cycles(s_cycles)
  );

  function automatic logic [39:0] mk(input logic e_err, input logic [1:0] e_code,
                                     input logic [3:0] e_src, input logic e_done,
                                     input logic [31:0] e_cyc);
    return {e_err, e_code, e_src, e_done, e_cyc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; heartbeat = 1'b0; halt = 1'b0; src_err = 4'h0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; heartbeat = 1'b1; halt = 1'b1; src_err = 4'hF;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'd0));
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_%0d: got %h expected %h", k, obs, e);
      end
    end
    rst = 1'b0; heartbeat = 1'b0; halt = 1'b0; src_err = 4'h0;
  endtask

  task automatic run_heartbeat_halt(input string tag);
    for (int i = 1; i <= 500; i++) begin
      heartbeat = ((i % 10) == 0);
      if ((i % 100) == 0) exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'(i)));
      step();
      if ((i % 100) == 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s_run_%0d: got %h expected %h", tag, i, obs, e);
        end
      end
    end
    heartbeat = 1'b0;
    halt = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 32'd501));
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s_halt: got %h expected %h", tag, obs, e);
    end
    n_checks++;
    if ({s_done, s_err, s_cycles} !== {1'b1, 1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL %s_saturate: got done=%b err=%b cycles=%h expected done=1 err=0 cycles=ff",
               tag, s_done, s_err, s_cycles);
    end
    halt = 1'b0;
    heartbeat = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 32'd501));
    repeat (3) step();
    heartbeat = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s_done_hold: got %h expected %h", tag, obs, e);
    end
  endtask

  task automatic test_normal_run();
    run_heartbeat_halt("t1");
  endtask

  task automatic test_timeout();
    apply_reset(2);
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'd15));
    repeat (15) step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_early: got %h expected %h", obs, e);
    end
    exp_q.push_back(mk(1'b1, 2'd1, 4'h0, 1'b0, 32'd16));
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_edge: got %h expected %h", obs, e);
    end
    src_err = 4'hA; halt = 1'b1; heartbeat = 1'b1;
    exp_q.push_back(mk(1'b1, 2'd1, 4'h0, 1'b0, 32'd16));
    repeat (2) step();
    src_err = 4'h0; halt = 1'b0; heartbeat = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_src_with_halt();
    apply_reset(1);
    repeat (3) step();
    src_err = 4'b0100; halt = 1'b1;
    exp_q.push_back(mk(1'b1, 2'd2, 4'b0100, 1'b0, 32'd4));
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL src_beats_halt: got %h expected %h", obs, e);
    end
    src_err = 4'h0;
    exp_q.push_back(mk(1'b1, 2'd2, 4'b0100, 1'b0, 32'd4));
    step();
    halt = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL src_sticky: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_post_halt();
    apply_reset(1);
    repeat (2) step();
    halt = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 32'd3));
    step();
    halt = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_halt_done: got %h expected %h", obs, e);
    end
    repeat (2) step();
    src_err = 4'b0001;
    exp_q.push_back(mk(1'b1, 2'd3, 4'b0001, 1'b1, 32'd3));
    step();
    src_err = 4'h0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_halt_fault: got %h expected %h", obs, e);
    end
    src_err = 4'h2;
    exp_q.push_back(mk(1'b1, 2'd3, 4'b0001, 1'b1, 32'd3));
    step();
    src_err = 4'h0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_halt_sticky: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_hb_boundary();
    apply_reset(1);
    repeat (15) step();
    heartbeat = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'd16));
    step();
    heartbeat = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL hb_on_timeout: got %h expected %h", obs, e);
    end
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'd31));
    repeat (15) step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL hb_restart: got %h expected %h", obs, e);
    end
    exp_q.push_back(mk(1'b1, 2'd1, 4'h0, 1'b0, 32'd32));
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL hb_second_timeout: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_reset_recovery();
    rst = 1'b1;
    exp_q.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 32'd0));
    step();
    rst = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL recover_reset: got %h expected %h", obs, e);
    end
    run_heartbeat_halt("t6");
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_timeout();
    test_src_with_halt();
    test_post_halt();
    test_hb_boundary();
    test_reset_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
